// File: rtl/split_byte_memory_pkg.sv
// split_byte_memory_pkg: address-select encodings and width constants
package split_byte_memory_pkg;
    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_R6   = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;
endpackage

// File: rtl/split_byte_memory_mem_bank8.sv
// mem_bank8: 8-bit RAM with synchronous write and asynchronous read
module mem_bank8 #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [2**AW];
    always_ff @(posedge clock) begin
        if (we) mem_q[addr] <= wdata;
    end
    assign rdata = mem_q[addr];
endmodule

// File: rtl/split_byte_memory.sv
// split_byte_memory: two-bank byte/word memory with mdr and ir load registers
module split_byte_memory #(
    parameter int AW = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  I,
    input  logic [15:0] PC,
    input  logic [15:0] R6,
    input  logic [15:0] AluOut,
    input  logic        ctrl,
    input  logic        memWr,
    input  logic        memRd,
    input  logic        mdr_l,
    input  logic        mdr_h,
    input  logic        ir_wr,
    input  logic [7:0]  regH,
    input  logic [7:0]  regL,
    output logic [15:0] mdr,
    output logic [15:0] ir
);
    import split_byte_memory_pkg::*;
    logic [ADDR_W-1:0] addr;
    logic [AW-1:0]     w;
    logic              lane, wr_ok, rd_ok, we_h, we_l;
    logic [BYTE_W-1:0] rd_h, rd_l;
    logic [WORD_W-1:0] mdr_d, mdr_q, ir_d, ir_q;
    logic              unused_addr;
    always_comb begin
        addr  = (I == SEL_PC)  ? PC :
                (I == SEL_R6)  ? R6 :
                (I == SEL_ALU) ? AluOut : '0;
        w     = addr[AW:1];
        lane  = addr[0];
        wr_ok = memWr & ~reset;
        rd_ok = memRd & ~memWr;
        we_h  = wr_ok & (ctrl | lane);
        we_l  = wr_ok & (ctrl | ~lane);
        mdr_d = {(rd_ok && mdr_h) ? rd_h : mdr_q[15:8],
                 (rd_ok && mdr_l) ? rd_l : mdr_q[7:0]};
        ir_d  = (rd_ok && ir_wr) ? {rd_h, rd_l} : ir_q;
    end
    assign unused_addr = ^addr[ADDR_W-1:AW+1];
    mem_bank8 #(.AW(AW)) u_mem_h (
        .clock(clock), .we(we_h), .addr(w), .wdata(regH), .rdata(rd_h)
    );
    mem_bank8 #(.AW(AW)) u_mem_l (
        .clock(clock), .we(we_l), .addr(w), .wdata(regL), .rdata(rd_l)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            mdr_q <= '0;
            ir_q  <= '0;
        end else begin
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
        end
    end
    assign mdr = mdr_q;
    assign ir  = ir_q;
endmodule

// File: tb/tb_split_byte_memory.sv
// tb_split_byte_memory: directed vectors with a queue-based register scoreboard
module tb_split_byte_memory;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  I = 2'b00;
    logic [15:0] PC = 16'd2, R6 = 16'd1, AluOut = 16'd3;
    logic        ctrl = 1'b0, memWr = 1'b0, memRd = 1'b0;
    logic        mdr_l = 1'b0, mdr_h = 1'b0, ir_wr = 1'b0;
    logic [7:0]  regH = 8'h00, regL = 8'h00;
    logic [15:0] mdr, ir;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        string       name;
        logic [15:0] mdr;
        logic [15:0] ir;
    } exp_t;
    exp_t q[$];
    exp_t e;

    split_byte_memory #(.AW(8)) dut (
        .clock(clock), .reset(reset), .I(I), .PC(PC), .R6(R6), .AluOut(AluOut),
        .ctrl(ctrl), .memWr(memWr), .memRd(memRd), .mdr_l(mdr_l), .mdr_h(mdr_h),
        .ir_wr(ir_wr), .regH(regH), .regL(regL), .mdr(mdr), .ir(ir)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (mdr !== e.mdr) begin
                n_bad++;
                $display("FAIL %s mdr: got %h want %h", e.name, mdr, e.mdr);
            end
            n_cmp++;
            if (ir !== e.ir) begin
                n_bad++;
                $display("FAIL %s ir: got %h want %h", e.name, ir, e.ir);
            end
        end
    end

    task automatic op(input logic rst, input logic [1:0] i, input logic c, input logic wr,
                      input logic rd, input logic ml, input logic mh, input logic iw,
                      input logic [7:0] h, input logic [7:0] l);
        reset = rst; I = i; ctrl = c; memWr = wr; memRd = rd;
        mdr_l = ml; mdr_h = mh; ir_wr = iw; regH = h; regL = l;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_regs(input string name, input logic [15:0] m, input logic [15:0] r);
        q.push_back('{name, m, r});
    endtask

    initial begin
        //  rst  I   c  wr rd ml mh iw  regH   regL
        op(1, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        op(1, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        expect_regs("reset", 16'h0000, 16'h0000);
        op(0, 2'b00, 1, 1, 0, 0, 0, 0, 8'hAA, 8'hBB);
        expect_regs("word_wr_w1", 16'h0000, 16'h0000);
        op(0, 2'b00, 0, 1, 0, 0, 0, 0, 8'h02, 8'h01);
        op(0, 2'b00, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        expect_regs("byte_low_only", 16'h0000, 16'hAA01);
        op(0, 2'b10, 0, 1, 0, 0, 0, 0, 8'h05, 8'h06);
        op(0, 2'b10, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        expect_regs("byte_high_only", 16'h0000, 16'h0501);
        op(0, 2'b01, 1, 1, 0, 0, 0, 0, 8'h04, 8'h03);
        op(0, 2'b10, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00);
        expect_regs("rd_mdr_l", 16'h0001, 16'h0501);
        op(0, 2'b00, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00);
        expect_regs("rd_mdr_h", 16'h0501, 16'h0501);
        op(0, 2'b01, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        expect_regs("rd_ir_word0", 16'h0501, 16'h0403);
        op(0, 2'b00, 0, 1, 1, 1, 0, 1, 8'h88, 8'h77);
        expect_regs("wr_priority_hold", 16'h0501, 16'h0403);
        op(0, 2'b00, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        expect_regs("wr_priority_wrote", 16'h0501, 16'h0577);
        op(1, 2'b01, 1, 1, 1, 1, 1, 1, 8'hEE, 8'hFF);
        expect_regs("reset_overrides", 16'h0000, 16'h0000);
        op(0, 2'b01, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        expect_regs("mem_kept_wr_blocked", 16'h0000, 16'h0403);
        op(0, 2'b11, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00);
        expect_regs("sel_zero", 16'h0403, 16'h0403);
        PC = 16'h0202;
        op(0, 2'b00, 0, 0, 1, 1, 0, 1, 8'h00, 8'h00);
        expect_regs("wrap_alias", 16'h0477, 16'h0577);
        op(0, 2'b01, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00);
        expect_regs("no_rd_hold", 16'h0477, 16'h0577);
        op(0, 2'b01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clock);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
